// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running h/v counters decoded into syncs, an active
// window, and a request window running one clock ahead for a registered pixel source.

module vga_axis #(
  parameter int TOTAL = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       last
);
  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  logic [9:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = last ? 10'd0 : cnt_q + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);
  // Window bounds carried at 11 bits so HA+H_VALID may reach 1024.
  localparam logic [10:0] HS    = 11'(H_SYNC);
  localparam logic [10:0] VS    = 11'(V_SYNC);
  localparam logic [10:0] HA    = 11'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [10:0] HE    = 11'(H_SYNC + H_BACK + H_LEFT + H_VALID);
  localparam logic [10:0] VA    = 11'(V_SYNC + V_BACK + V_TOP);
  localparam logic [10:0] VE    = 11'(V_SYNC + V_BACK + V_TOP + V_VALID);
  localparam logic [9:0]  HA_M1 = 10'(H_SYNC + H_BACK + H_LEFT - 1);
  localparam logic [9:0]  VA_10 = 10'(V_SYNC + V_BACK + V_TOP);

  if ((H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT != H_TOTAL) ||
      (H_TOTAL > 1024)) begin : g_bad_h
    $error("vga_ctrl: horizontal timing does not sum to H_TOTAL or exceeds 1024");
  end
  if ((V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT != V_TOTAL) ||
      (V_TOTAL > 1024)) begin : g_bad_v
    $error("vga_ctrl: vertical timing does not sum to V_TOTAL or exceeds 1024");
  end

  logic [9:0]  cnt_h, cnt_v;
  logic        h_last, v_last;
  logic [10:0] h11, v11;
  logic        h_act, h_req, v_act, pix_data_req;

  vga_axis #(.TOTAL(H_TOTAL)) u_h (
    .clk(vga_clk), .rst_n(sys_rst_n), .en(1'b1), .cnt(cnt_h), .last(h_last)
  );
  vga_axis #(.TOTAL(V_TOTAL)) u_v (
    .clk(vga_clk), .rst_n(sys_rst_n), .en(h_last), .cnt(cnt_v), .last(v_last)
  );

  assign h11 = {1'b0, cnt_h};
  assign v11 = {1'b0, cnt_v};

  assign hsync = (h11 < HS);
  assign vsync = (v11 < VS);

  // The request window leads the active window by one clock so the generator's
  // registered output lines up with the active pixel it belongs to.
  assign h_act        = (h11 >= HA) && (h11 < HE);
  assign h_req        = (h11 >= HA - 11'd1) && (h11 < HE - 11'd1);
  assign v_act        = (v11 >= VA) && (v11 < VE);
  assign rgb_valid    = h_act && v_act;
  assign pix_data_req = h_req && v_act;

  assign pix_x = pix_data_req ? (cnt_h - HA_M1) : 10'h3FF;
  assign pix_y = pix_data_req ? (cnt_v - VA_10) : 10'h3FF;
  assign rgb   = rgb_valid ? pix_data : 16'h0000;

  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_start_d = h_last && v_last;
    frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl using a shrunken timing so that 256 frames stay short;
// expectations come from cycle-index arithmetic, not from a counter model.

module tb_vga_ctrl;
  localparam int HSY = 3, HBK = 2, HLF = 1, HVL = 8, HRT = 1, HFR = 1;
  localparam int HT  = HSY + HBK + HLF + HVL + HRT + HFR;   // 16
  localparam int VSY = 2, VBK = 1, VTP = 1, VVL = 5, VBT = 1, VFR = 1;
  localparam int VT  = VSY + VBK + VTP + VVL + VBT + VFR;   // 11
  localparam int HA  = HSY + HBK + HLF;
  localparam int VA  = VSY + VBK + VTP;
  localparam int FL  = HT * VT;

  typedef struct packed {
    logic       hs, vs, rv;
    logic [9:0] px, py;
    logic [15:0] rgb;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  localparam out_t RST = '{hs: 1'b1, vs: 1'b1, rv: 1'b0, px: 10'h3FF, py: 10'h3FF,
                           rgb: 16'h0, fs: 1'b0, fc: 8'd0};

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pix_data, rnd_data = 16'h0, gen_q = 16'h0;
  logic        use_gen = 1'b0;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, rgb_valid, frame_start;
  logic [15:0] rgb;
  logic [7:0]  frame_cnt;
  out_t        obs, e;

  int t = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  // Registered picture-generator model: pixel value is the column requested last clock.
  always @(posedge vga_clk) gen_q <= {6'd0, pix_x};
  assign pix_data = use_gen ? gen_q : rnd_data;

  vga_ctrl #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_LEFT(HLF), .H_VALID(HVL), .H_RIGHT(HRT),
    .H_FRONT(HFR), .H_TOTAL(HT), .V_SYNC(VSY), .V_BACK(VBK), .V_TOP(VTP),
    .V_VALID(VVL), .V_BOTTOM(VBT), .V_FRONT(VFR), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  assign obs = {hsync, vsync, rgb_valid, pix_x, pix_y, rgb, frame_start, frame_cnt};

  // Expected outputs t clocks after reset release, given the current pixel input.
  function automatic out_t model(int tt, logic [15:0] pd);
    out_t r;
    int h = tt % HT;
    int v = (tt / HT) % VT;
    bit vin = (v >= VA) && (v < VA + VVL);
    bit req = (h >= HA - 1) && (h < HA + HVL - 1) && vin;
    r.hs  = (h < HSY);
    r.vs  = (v < VSY);
    r.rv  = (h >= HA) && (h < HA + HVL) && vin;
    r.px  = req ? 10'(h - HA + 1) : 10'h3FF;
    r.py  = req ? 10'(v - VA) : 10'h3FF;
    r.rgb = r.rv ? pd : 16'h0;
    r.fs  = (tt > 0) && (tt % FL == 0);
    r.fc  = 8'(tt / FL);
    return r;
  endfunction

  task automatic step();
    @(posedge vga_clk);
    t++;
    #1 rnd_data = 16'($urandom);
    @(negedge vga_clk);
  endtask

  task automatic run_to(int target);
    while (t < target) step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      rnd_data = 16'($urandom);
      #1;
      n_cmp++;
      if (obs !== RST) begin
        n_err++;
        $display("FAIL reset_hold got=%h exp=%h", obs, RST);
      end
    end
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    t = 0;
    #1;
    e = model(0, pix_data);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_hline();
    int hs_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      if (i > 0) step();
      if (hsync === 1'b1) hs_cnt++;
      if (i == HT - 1) begin
        n_cmp++;
        if (dut.cnt_v !== 10'd0) begin
          n_err++;
          $display("FAIL cnt_v_before_wrap got=%0d exp=0", dut.cnt_v);
        end
      end
    end
    n_cmp++;
    if (hs_cnt != HSY) begin
      n_err++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, HSY);
    end
    step();
    n_cmp++;
    if (dut.cnt_v !== 10'd1) begin
      n_err++;
      $display("FAIL cnt_v_step got=%0d exp=1", dut.cnt_v);
    end
  endtask

  task automatic test_frame();
    int vs_cnt = 0, rv_cnt = 0, fs_cnt = 0;
    for (int i = 0; i <= FL; i++) begin
      run_to(i);
      e = model(t, pix_data);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL frame_cycle t=%0d got=%h exp=%h", t, obs, e);
      end
      if (t < FL) begin
        if (vsync === 1'b1) vs_cnt++;
        if (rgb_valid === 1'b1) rv_cnt++;
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (vs_cnt != VSY * HT) begin
      n_err++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, VSY * HT);
    end
    n_cmp++;
    if (rv_cnt != HVL * VVL) begin
      n_err++;
      $display("FAIL valid_count got=%0d exp=%0d", rv_cnt, HVL * VVL);
    end
    n_cmp++;
    if (fs_cnt != 1 || frame_start !== 1'b1 || frame_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL first_frame_end got fs_cnt=%0d fs=%b fc=%0d exp 1/1/1",
               fs_cnt, frame_start, frame_cnt);
    end
  endtask

  task automatic test_mapping();
    int ls = (t / FL + 1) * FL + VA * HT;
    use_gen = 1'b1;
    run_to(ls + HA - 1);
    n_cmp++;
    if (pix_x !== 10'd0) begin
      n_err++;
      $display("FAIL map_first_req got=%h exp=0", pix_x);
    end
    for (int h = HA; h < HA + HVL; h++) begin
      run_to(ls + h);
      n_cmp++;
      if (rgb !== 16'(h - HA) || rgb_valid !== 1'b1) begin
        n_err++;
        $display("FAIL map_pixel h=%0d got rgb=%h rv=%b exp rgb=%h rv=1",
                 h, rgb, rgb_valid, 16'(h - HA));
      end
      if (h == HA + HVL - 2) begin
        n_cmp++;
        if (pix_x !== 10'(HVL - 1)) begin
          n_err++;
          $display("FAIL map_last_req got=%h exp=%h", pix_x, 10'(HVL - 1));
        end
      end
      if (h == HA + HVL - 1) begin
        n_cmp++;
        if (pix_x !== 10'h3FF) begin
          n_err++;
          $display("FAIL map_after_req got=%h exp=3ff", pix_x);
        end
      end
    end
    use_gen = 1'b0;
  endtask

  task automatic test_last_line();
    int ls = (t / FL + 1) * FL + (VA + VVL - 1) * HT;
    run_to(ls + HA + HVL / 2);
    n_cmp++;
    if (pix_y !== 10'(VVL - 1) || rgb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL last_line got py=%h rv=%b exp py=%h rv=1", pix_y, rgb_valid, 10'(VVL - 1));
    end
    for (int h = 0; h < HT; h++) begin
      run_to(ls + HT + h);
      n_cmp++;
      if (pix_y !== 10'h3FF || rgb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL below_window h=%0d got py=%h rv=%b exp py=3ff rv=0", h, pix_y, rgb_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    int t0 = (t / FL + 1) * FL + (VA + int'($urandom_range(VVL - 1))) * HT
             + int'($urandom_range(HT - 1));
    run_to(t0);
    rnd_data = 16'hA5C3;
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== RST) begin
      n_err++;
      $display("FAIL async_reset t=%0d got=%h exp=%h", t0, obs, RST);
    end
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    n_cmp++;
    if (obs !== RST) begin
      n_err++;
      $display("FAIL reset_clocked got=%h exp=%h", obs, RST);
    end
    sys_rst_n = 1'b1;
    t = 0;
  endtask

  task automatic test_back_to_back_frames();
    int fs_cnt = 0;
    for (int i = 0; i <= 256 * FL + 2; i++) begin
      run_to(i);
      e = model(t, pix_data);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL multi_frame t=%0d got=%h exp=%h", t, obs, e);
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (t == 256 * FL) begin
        n_cmp++;
        if (frame_cnt !== 8'd0 || frame_start !== 1'b1) begin
          n_err++;
          $display("FAIL frame_cnt_wrap got fc=%0d fs=%b exp fc=0 fs=1", frame_cnt, frame_start);
        end
      end
    end
    n_cmp++;
    if (fs_cnt != 256) begin
      n_err++;
      $display("FAIL frame_start_count got=%0d exp=256", fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_frame();
    test_mapping();
    test_last_line();
    test_async_reset();
    test_back_to_back_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
